// File: rtl/reg_file_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port between
// NUM_REQ requesters and registers the winning write onto the decoder interface.
module reg_file_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_wr_en,
  input  logic [10*NUM_REQ-1:0]   req_addr,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [1:0]              wr_en,
  output logic [9:0]              wr_addr,
  output logic [15:0]             data_out,
  output logic [PTR_W-1:0]        grant_id,
  output logic                    collision
);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]       wr_en_q, wr_en_d;
  logic [9:0]       wr_addr_q, wr_addr_d;
  logic [15:0]      data_q, data_d;
  logic [PTR_W-1:0] grant_id_q, grant_id_d;
  logic             collision_q, collision_d;

  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [1:0]       sel_wr_en;
  logic [9:0]       sel_addr;
  logic [15:0]      sel_data;
  logic             lane_clash;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return PTR_W'(sum % NUM_REQ);
  endfunction

  // Search begins just after the last winner so every requester gets a turn.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    if (!reset && !hold) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!grant_found && req_valid[wrap_idx(rr_ptr_q, k)]) begin
          grant_found = 1'b1;
          grant_idx   = wrap_idx(rr_ptr_q, k);
        end
      end
    end
    req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    sel_wr_en  = req_wr_en[2*grant_idx +: 2];
    sel_addr   = req_addr[10*grant_idx +: 10];
    sel_data   = req_data[16*grant_idx +: 16];
    lane_clash = (sel_wr_en == 2'b11) && (sel_addr[4:0] == sel_addr[9:5]);

    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = 2'b00;
    wr_addr_d   = wr_addr_q;
    data_d      = data_q;
    grant_id_d  = grant_id_q;
    collision_d = 1'b0;
    if (grant_found) begin
      rr_ptr_d    = grant_idx;
      // Both lanes hit the same byte: lane1 wins and lane0 is dropped.
      wr_en_d     = lane_clash ? 2'b10 : sel_wr_en;
      wr_addr_d   = sel_addr;
      data_d      = sel_data;
      grant_id_d  = grant_idx;
      collision_d = lane_clash;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
      wr_en_q     <= 2'b00;
      wr_addr_q   <= '0;
      data_q      <= '0;
      grant_id_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      data_q      <= data_d;
      grant_id_q  <= grant_id_d;
      collision_q <= collision_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign data_out  = data_q;
  assign grant_id  = grant_id_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Directed, table-driven bench for reg_file_write_arbiter (NUM_REQ=3): each
// vector checks combinational req_ready, then the registered outputs one edge later.
module tb_reg_file_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [5:0]  req_wr_en;
  logic [29:0] req_addr;
  logic [47:0] req_data;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] data_out;
  logic [1:0]  grant_id;
  logic        collision;

  int total = 0;
  int bad   = 0;

  reg_file_write_arbiter #(.NUM_REQ(3), .PTR_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr_en (req_wr_en),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .data_out  (data_out),
    .grant_id  (grant_id),
    .collision (collision)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        hold;
    logic [2:0]  valid;
    logic [5:0]  we;
    logic [29:0] addr;
    logic [47:0] data;
    logic [2:0]  exp_ready;
    logic [1:0]  exp_we;
    logic [9:0]  exp_addr;
    logic [15:0] exp_data;
    logic [1:0]  exp_gid;
    logic        exp_coll;
  } vec_t;

  localparam logic [5:0]  WE_P = {2'b01, 2'b01, 2'b01};
  localparam logic [29:0] AD_P = {10'h007, 10'h005, 10'h003};
  localparam logic [47:0] DA_P = {16'h00CC, 16'h00BB, 16'h00AA};

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic h, input logic [2:0] v, input logic [5:0] we,
                              input logic [29:0] ad, input logic [47:0] da,
                              input logic [2:0] rdy, input logic [1:0] owe,
                              input logic [9:0] oad, input logic [15:0] oda,
                              input logic [1:0] gid, input logic coll);
    vec_t r;
    r.hold = h; r.valid = v; r.we = we; r.addr = ad; r.data = da;
    r.exp_ready = rdy; r.exp_we = owe; r.exp_addr = oad; r.exp_data = oda;
    r.exp_gid = gid; r.exp_coll = coll;
    return r;
  endfunction

  // Drives one vector just after a rising edge, checks ready mid-cycle, outputs after the edge.
  task automatic apply(input vec_t v, input string tag);
    hold = v.hold; req_valid = v.valid; req_wr_en = v.we; req_addr = v.addr; req_data = v.data;
    @(negedge clock);
    check({tag, ".ready"}, 32'(req_ready), 32'(v.exp_ready));
    @(posedge clock); #1;
    check({tag, ".wr_en"},     32'(wr_en),     32'(v.exp_we));
    check({tag, ".wr_addr"},   32'(wr_addr),   32'(v.exp_addr));
    check({tag, ".data_out"},  32'(data_out),  32'(v.exp_data));
    check({tag, ".grant_id"},  32'(grant_id),  32'(v.exp_gid));
    check({tag, ".collision"}, 32'(collision), 32'(v.exp_coll));
  endtask

  initial begin
    // Round-robin through all three, then 0/2 alternation.
    vecs.push_back(mk(0, 3'b111, WE_P, AD_P, DA_P, 3'b001, 2'b01, 10'h003, 16'h00AA, 2'd0, 0));
    vecs.push_back(mk(0, 3'b110, WE_P, AD_P, DA_P, 3'b010, 2'b01, 10'h005, 16'h00BB, 2'd1, 0));
    vecs.push_back(mk(0, 3'b100, WE_P, AD_P, DA_P, 3'b100, 2'b01, 10'h007, 16'h00CC, 2'd2, 0));
    vecs.push_back(mk(0, 3'b101, WE_P, AD_P, DA_P, 3'b001, 2'b01, 10'h003, 16'h00AA, 2'd0, 0));
    vecs.push_back(mk(0, 3'b101, WE_P, AD_P, DA_P, 3'b100, 2'b01, 10'h007, 16'h00CC, 2'd2, 0));
    vecs.push_back(mk(0, 3'b101, WE_P, AD_P, DA_P, 3'b001, 2'b01, 10'h003, 16'h00AA, 2'd0, 0));
    vecs.push_back(mk(0, 3'b101, WE_P, AD_P, DA_P, 3'b100, 2'b01, 10'h007, 16'h00CC, 2'd2, 0));
    // Same-byte collision, then same register different byte.
    vecs.push_back(mk(0, 3'b010, {2'b01, 2'b11, 2'b01}, {10'h007, 10'h084, 10'h003},
                      {16'h00CC, 16'h1234, 16'h00AA}, 3'b010, 2'b10, 10'h084, 16'h1234, 2'd1, 1));
    vecs.push_back(mk(0, 3'b010, {2'b01, 2'b11, 2'b01}, {10'h007, 10'h284, 10'h003},
                      {16'h00CC, 16'h1234, 16'h00AA}, 3'b010, 2'b11, 10'h284, 16'h1234, 2'd1, 0));
    // Grant just before hold, three held cycles, then resume from saved pointer.
    vecs.push_back(mk(0, 3'b001, WE_P, AD_P, DA_P, 3'b001, 2'b01, 10'h003, 16'h00AA, 2'd0, 0));
    vecs.push_back(mk(1, 3'b111, WE_P, AD_P, DA_P, 3'b000, 2'b00, 10'h003, 16'h00AA, 2'd0, 0));
    vecs.push_back(mk(1, 3'b111, WE_P, AD_P, DA_P, 3'b000, 2'b00, 10'h003, 16'h00AA, 2'd0, 0));
    vecs.push_back(mk(1, 3'b111, WE_P, AD_P, DA_P, 3'b000, 2'b00, 10'h003, 16'h00AA, 2'd0, 0));
    vecs.push_back(mk(0, 3'b111, WE_P, AD_P, DA_P, 3'b010, 2'b01, 10'h005, 16'h00BB, 2'd1, 0));
    // Empty write from requester 2 still consumes the grant.
    vecs.push_back(mk(0, 3'b100, {2'b00, 2'b01, 2'b01}, {10'h00F, 10'h005, 10'h003},
                      {16'hBEEF, 16'h00BB, 16'h00AA}, 3'b100, 2'b00, 10'h00F, 16'hBEEF, 2'd2, 0));
    vecs.push_back(mk(0, 3'b111, WE_P, AD_P, DA_P, 3'b001, 2'b01, 10'h003, 16'h00AA, 2'd0, 0));
    // Idle cycle: wr_en clears, payload holds.
    vecs.push_back(mk(0, 3'b000, WE_P, AD_P, DA_P, 3'b000, 2'b00, 10'h003, 16'h00AA, 2'd0, 0));
    // Collision flag lasts a single cycle.
    vecs.push_back(mk(0, 3'b001, {2'b01, 2'b01, 2'b11}, {10'h007, 10'h005, 10'h3FF},
                      {16'h00CC, 16'h00BB, 16'h5A5A}, 3'b001, 2'b10, 10'h3FF, 16'h5A5A, 2'd0, 1));
    vecs.push_back(mk(0, 3'b000, WE_P, AD_P, DA_P, 3'b000, 2'b00, 10'h3FF, 16'h5A5A, 2'd0, 0));

    reset = 1'b1; hold = 1'b0; req_valid = 3'b111;
    req_wr_en = WE_P; req_addr = AD_P; req_data = DA_P;
    @(negedge clock);
    check("rst.ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    check("rst.wr_en", 32'(wr_en), 32'd0);
    check("rst.wr_addr", 32'(wr_addr), 32'd0);
    check("rst.data_out", 32'(data_out), 32'd0);
    check("rst.grant_id", 32'(grant_id), 32'd0);
    check("rst.collision", 32'(collision), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Mid-stream reset with requester 1 pending: not accepted, outputs cleared.
    hold = 1'b0; req_valid = 3'b010; req_wr_en = WE_P; req_addr = AD_P; req_data = DA_P;
    @(negedge clock);
    check("mid.pre_ready", 32'(req_ready), 32'b010);
    reset = 1'b1;
    #1 check("mid.rst_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    check("mid.wr_en", 32'(wr_en), 32'd0);
    check("mid.wr_addr", 32'(wr_addr), 32'd0);
    check("mid.data_out", 32'(data_out), 32'd0);
    check("mid.grant_id", 32'(grant_id), 32'd0);
    reset = 1'b0;
    // After release requester 0 is searched first.
    apply(mk(0, 3'b011, WE_P, AD_P, DA_P, 3'b001, 2'b01, 10'h003, 16'h00AA, 2'd0, 0), "post0");
    apply(mk(0, 3'b010, WE_P, AD_P, DA_P, 3'b010, 2'b01, 10'h005, 16'h00BB, 2'd1, 0), "post1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
